// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit.
// Produces a 64-bit result as HI/LO words: product halves, or remainder/quotient.
module mul_div_unit #(
  parameter logic [4:0] MUL_OP = 5'b01111,
  parameter logic [4:0] DIV_OP = 5'b10000,
  parameter int         WIDTH  = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_r;
  logic [CW-1:0]    cnt_r;
  logic             is_div_r;
  logic             neg_q_r;
  logic             neg_r_r;
  logic [WIDTH:0]   acc_r;
  logic [WIDTH-1:0] q_r;
  logic             qm1_r;
  logic [WIDTH:0]   m_r;

  logic             is_mul_s;
  logic             is_div_s;
  logic             accept_s;
  logic             b_zero_s;
  logic [WIDTH-1:0] a_mag_s;
  logic [WIDTH-1:0] b_mag_s;
  logic [WIDTH:0]   shl_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   acc_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic             qm1_next_s;
  logic [WIDTH-1:0] rem_fix_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] quot_s;
  logic [WIDTH-1:0] fix_hi_s;
  logic [WIDTH-1:0] fix_lo_s;

  assign is_mul_s = (opcode == MUL_OP);
  assign is_div_s = (opcode == DIV_OP);
  assign accept_s = (state_r == IDLE) && start && (is_mul_s || is_div_s);
  assign b_zero_s = (input_b == {WIDTH{1'b0}});

  // Operand magnitudes for division; the most negative value maps onto itself as unsigned.
  always_comb begin
    a_mag_s = input_a;
    b_mag_s = input_b;
    if (input_a[WIDTH-1]) a_mag_s = -input_a;
    else                  a_mag_s = input_a;
    if (input_b[WIDTH-1]) b_mag_s = -input_b;
    else                  b_mag_s = input_b;
  end

  // One iteration: Booth add/sub then arithmetic shift, or one non-restoring divide step.
  always_comb begin
    shl_s      = {acc_r[WIDTH-1:0], q_r[WIDTH-1]};
    sum_s      = acc_r;
    acc_next_s = acc_r;
    q_next_s   = q_r;
    qm1_next_s = qm1_r;
    if (is_div_r) begin
      if (acc_r[WIDTH]) sum_s = shl_s + m_r;
      else              sum_s = shl_s - m_r;
      acc_next_s = sum_s;
      q_next_s   = {q_r[WIDTH-2:0], ~sum_s[WIDTH]};
      qm1_next_s = 1'b0;
    end else begin
      case ({q_r[0], qm1_r})
        2'b01:   sum_s = acc_r + m_r;
        2'b10:   sum_s = acc_r - m_r;
        default: sum_s = acc_r;
      endcase
      {acc_next_s, q_next_s, qm1_next_s} = {sum_s[WIDTH], sum_s, q_r};
    end
  end

  // Final correction: restore a negative remainder, then apply result signs.
  always_comb begin
    rem_fix_s = acc_r[WIDTH-1:0];
    rem_s     = rem_fix_s;
    quot_s    = q_r;
    fix_hi_s  = acc_r[WIDTH-1:0];
    fix_lo_s  = q_r;
    if (acc_r[WIDTH]) rem_fix_s = acc_r[WIDTH-1:0] + m_r[WIDTH-1:0];
    else              rem_fix_s = acc_r[WIDTH-1:0];
    if (neg_q_r) quot_s = -q_r;
    else         quot_s = q_r;
    if (neg_r_r) rem_s = -rem_fix_s;
    else         rem_s = rem_fix_s;
    if (is_div_r) begin
      fix_hi_s = rem_s;
      fix_lo_s = quot_s;
    end else begin
      fix_hi_s = acc_r[WIDTH-1:0];
      fix_lo_s = q_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      is_div_r    <= 1'b0;
      neg_q_r     <= 1'b0;
      neg_r_r     <= 1'b0;
      acc_r       <= {(WIDTH+1){1'b0}};
      q_r         <= {WIDTH{1'b0}};
      qm1_r       <= 1'b0;
      m_r         <= {(WIDTH+1){1'b0}};
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      result_hi   <= {WIDTH{1'b0}};
      result_lo   <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            div_by_zero <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            is_div_r    <= is_div_s;
            acc_r       <= {(WIDTH+1){1'b0}};
            qm1_r       <= 1'b0;
            if (is_div_s && b_zero_s) begin
              state_r     <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              result_hi   <= input_a;
              result_lo   <= {WIDTH{1'b1}};
            end else if (is_div_s) begin
              state_r <= CALC;
              busy    <= 1'b1;
              q_r     <= a_mag_s;
              m_r     <= {1'b0, b_mag_s};
              neg_q_r <= input_a[WIDTH-1] ^ input_b[WIDTH-1];
              neg_r_r <= input_a[WIDTH-1];
            end else begin
              state_r <= CALC;
              busy    <= 1'b1;
              q_r     <= input_b;
              m_r     <= {input_a[WIDTH-1], input_a};
              neg_q_r <= 1'b0;
              neg_r_r <= 1'b0;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r <= acc_next_s;
          q_r   <= q_next_s;
          qm1_r <= qm1_next_s;
          if (cnt_r == LAST) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r + ONE;
          end
        end
        FIX: begin
          result_hi <= fix_hi_s;
          result_lo <= fix_lo_s;
          done      <= 1'b1;
          busy      <= 1'b0;
          state_r   <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomised and directed bench for mul_div_unit against a latency/arithmetic
// reference model built from plain 64-bit integer arithmetic.
module tb_mul_div_unit;

  localparam logic [4:0] MUL_OP = 5'b01111;
  localparam logic [4:0] DIV_OP = 5'b10000;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [4:0]  opcode  = 5'd0;
  logic [31:0] input_a = 32'd0;
  logic [31:0] input_b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result_hi;
  logic [31:0] result_lo;
  logic        div_by_zero;

  int vectors     = 0;
  int miscompares = 0;

  mul_div_unit #(.MUL_OP(MUL_OP), .DIV_OP(DIV_OP), .WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .input_a(input_a), .input_b(input_b), .busy(busy), .done(done),
    .result_hi(result_hi), .result_lo(result_lo), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  // Reference arithmetic: {div_by_zero, hi, lo}
  function automatic logic [64:0] ref_op(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint p, qa, qb, q, r;
    if (op == MUL_OP) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return {1'b0, p[63:0]};
    end else if (b == 32'd0) begin
      return {1'b1, a, 32'hFFFFFFFF};
    end else begin
      qa = longint'($signed(a));
      qb = longint'($signed(b));
      q  = qa / qb;
      r  = qa % qb;
      return {1'b0, r[31:0], q[31:0]};
    end
  endfunction

  logic [64:0] cur_ref;
  always_comb cur_ref = ref_op(opcode, input_a, input_b);

  // Model state: outputs as the unit must present them, driven by a countdown to done.
  logic        m_busy, m_done, m_dbz;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;
  int          m_left;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_hi <= 32'd0; m_lo <= 32'd0; m_pend <= 64'd0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1;
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        end
      end else if (!m_done && start && (opcode == MUL_OP || opcode == DIV_OP)) begin
        m_dbz <= 1'b0;
        if (opcode == DIV_OP && input_b == 32'd0) begin
          m_done <= 1'b1; m_dbz <= 1'b1; m_hi <= input_a; m_lo <= 32'hFFFFFFFF;
        end else begin
          m_busy <= 1'b1; m_left <= 33; m_pend <= cur_ref[63:0];
        end
      end
    end
  end

  task automatic check(input string name, input logic [98:0] act, input logic [98:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle, mid-phase: {busy, done, div_by_zero, hi, lo} against the model.
  always @(negedge clock) begin
    check("cycle", {busy, done, div_by_zero, result_hi, result_lo},
          {m_busy, m_done, m_dbz, m_hi, m_lo});
  end

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h00000000;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  function automatic logic [4:0] pick_op();
    case ($urandom_range(0, 4))
      0, 1:    return MUL_OP;
      2, 3:    return DIV_OP;
      default: return 5'($urandom);
    endcase
  endfunction

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clock); #2;
    start = 1'b1; opcode = op; input_a = a; input_b = b;
    @(posedge clock); #2;
    start = 1'b0; opcode = 5'($urandom); input_a = 32'($urandom); input_b = 32'($urandom);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: done=%b expected 1 within 40 cycles", name, done);
    end
  endtask

  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [64:0] exp);
    issue(op, a, b);
    wait_done(name);
    #1;
    check(name, {busy, done, div_by_zero, result_hi, result_lo}, {2'b01, exp});
  endtask

  initial begin
    // Pin the reference model with hand-computed values.
    check("pin_mul", ref_op(MUL_OP, 32'd3, 32'hFFFFFFFC), {1'b0, 64'hFFFFFFFF_FFFFFFF4});
    check("pin_div", ref_op(DIV_OP, 32'hFFFFFFEF, 32'd5), {1'b0, 64'hFFFFFFFE_FFFFFFFD});
    check("pin_ovf", ref_op(DIV_OP, 32'h80000000, 32'hFFFFFFFF), {1'b0, 64'h00000000_80000000});
    check("pin_dbz", ref_op(DIV_OP, 32'd17, 32'd0), {1'b1, 64'h00000011_FFFFFFFF});

    #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    #1 check("reset", {busy, done, div_by_zero, result_hi, result_lo}, 99'd0);

    issue(5'd0, 32'd5, 32'd6);
    repeat (3) @(posedge clock);
    #3 check("bad_opcode", {busy, done}, 99'd0);

    run_op("mul_3_m4",  MUL_OP, 32'd3, 32'hFFFFFFFC, {1'b0, 64'hFFFFFFFF_FFFFFFF4});
    run_op("mul_min2",  MUL_OP, 32'h80000000, 32'h80000000, {1'b0, 64'h40000000_00000000});
    run_op("mul_12_17", MUL_OP, 32'd12, 32'd17, {1'b0, 64'h00000000_000000CC});
    run_op("div_17_5",  DIV_OP, 32'd17, 32'd5, {1'b0, 64'h00000002_00000003});
    run_op("div_m17_5", DIV_OP, 32'hFFFFFFEF, 32'd5, {1'b0, 64'hFFFFFFFE_FFFFFFFD});
    run_op("div_17_m5", DIV_OP, 32'd17, 32'hFFFFFFFB, {1'b0, 64'h00000002_FFFFFFFD});
    run_op("div_zero",  DIV_OP, 32'd17, 32'd0, {1'b1, 64'h00000011_FFFFFFFF});

    issue(MUL_OP, 32'd2, 32'd3);
    #1 check("dbz_clear", {busy, div_by_zero}, 99'b10);
    wait_done("mul_2_3");
    #1 check("mul_2_3", {busy, done, div_by_zero, result_hi, result_lo},
             {3'b010, 64'h00000000_00000006});

    run_op("div_ovf", DIV_OP, 32'h80000000, 32'hFFFFFFFF, {1'b0, 64'h00000000_80000000});

    // A second start while busy must not disturb the running multiply.
    issue(MUL_OP, 32'd7, 32'hFFFFFFF7);
    repeat (8) @(posedge clock);
    issue(DIV_OP, 32'd100, 32'd7);
    wait_done("mul_ignored_start");
    #1 check("mul_ignored_start", {busy, done, div_by_zero, result_hi, result_lo},
             {3'b010, 64'hFFFFFFFF_FFFFFFC1});

    issue(MUL_OP, 32'd5, 32'd6);
    repeat (18) @(posedge clock);
    #2 reset_n = 1'b0;
    #1 check("reset_abort", {busy, done, div_by_zero, result_hi, result_lo}, 99'd0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    run_op("mul_after_reset", MUL_OP, 32'd1000, 32'hFFFFFFFD, {1'b0, 64'hFFFFFFFF_FFFFF448});

    for (int i = 0; i < 3000; i++) begin
      @(posedge clock); #2;
      start   = ($urandom_range(0, 2) == 0);
      opcode  = pick_op();
      input_a = pick_val();
      input_b = pick_val();
    end
    @(posedge clock); #2;
    start = 1'b0;
    repeat (40) @(posedge clock);
    #7;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
